ps2_kbd_ctrl: RTL and testbench
===============================

Name: ps2_kbd_ctrl

Overview:
Host-side PS/2 keyboard receive controller between the raw PS/2 pins and the game logic in Top.
- Synchronises and deglitches PS2_CLK and PS2_DAT.
- Sequences the 11-bit device-to-host frame through an FSM.
- Checks parity, stop bit and inter-edge timeout.
- Folds E0/F0 prefixes into single key events for the game FSM and LED debug.

Parameters:
FILTER_LEN, 8, consecutive identical i_clk samples needed before the filtered PS/2 clock changes level.
TIMEOUT_CYC, 100000, maximum i_clk cycles between PS/2 falling edges inside a frame (2 ms at 50 MHz).

Ports:
i_clk  input  1  system clock, 50 MHz
i_rst  input  1  asynchronous, active-high reset
i_ps2_clk  input  1  raw PS/2 clock, asynchronous to i_clk
i_ps2_data  input  1  raw PS/2 data, asynchronous to i_clk
o_byte_valid  output  1  one-cycle pulse when a frame is received without error
o_byte  output  8  last good raw byte; held between pulses
o_key_valid  output  1  one-cycle key-event pulse
o_key_code  output  8  scan code of the event
o_key_ext  output  1  event was preceded by E0
o_key_break  output  1  event is a release (F0 seen)
o_sys_valid  output  1  one-cycle pulse for a system byte (AA, FA, FE, EE, 00, FF) seen with no prefix pending
o_err  output  1  one-cycle error pulse
o_err_code  output  2  0 none, 1 parity, 2 framing (stop bit 0), 3 timeout; held until next o_err
o_busy  output  1  high while FSM is not IDLE

Behaviour:
Reset (async, active-high):
- All outputs 0, FSM IDLE, prefix flags cleared.
- Filtered clock and data registers reset to 1.

Input conditioning:
- Both inputs pass through 2-FF synchronisers.
- Clock glitch filter: the filtered level changes only after FILTER_LEN identical consecutive synced samples.
- A falling edge is a 1->0 transition of the filtered clock, one-cycle strobe `fe`.
- Data is sampled on the `fe` cycle from the synced data (no filter).

Frame FSM, advanced only on `fe` except for timeout:
- IDLE: on `fe` with data 0 -> DATA, bit count 0. On `fe` with data 1 -> stay IDLE, no error.
- DATA: shift data in LSB-first; after the 8th bit -> PARITY.
- PARITY: store bit -> STOP.
- STOP:
  - data 1 and odd parity over 9 bits -> DONE.
  - parity bad -> ERR, code 1.
  - stop bit 0 -> ERR, code 2. Parity check has priority.
- DONE: one cycle. o_byte_valid=1, o_byte updated -> IDLE.
- ERR: one cycle. o_err=1, prefix flags cleared, byte dropped -> IDLE.

Timeout:
- Timeout counter resets on every `fe`; counts only while not IDLE.
- Reaching TIMEOUT_CYC from DATA, PARITY or STOP -> ERR, code 3.
- `fe` in the same cycle as the count reaching TIMEOUT_CYC: the edge wins.

Key decode, in the cycle after DONE (2 cycles after the stop-bit `fe`):
- E0: set ext flag, no event.
- F0: set brk flag, no event.
- System byte with both flags clear: o_sys_valid pulse, no key event.
- Otherwise:
  - o_key_valid pulse.
  - o_key_code = byte, o_key_ext = ext flag, o_key_break = brk flag.
  - Both flags clear in the same cycle.
- E0 E0 keeps ext=1. F0 then E0 sets ext with brk retained.
- Key outputs hold their values between pulses.

o_busy = (state != IDLE).

Decomposition:
- Package ps2_pkg:
  - state enum {IDLE, DATA, PARITY, STOP, DONE, ERR}.
  - err_code enum {ERR_NONE, ERR_PARITY, ERR_FRAME, ERR_TIMEOUT}.
  - Constants: PREFIX_EXT=8'hE0, PREFIX_BRK=8'hF0, and the system-byte list.
- Sub-module ps2_sync_filter (2-FF sync + FILTER_LEN debounce + `fe` strobe), one instance for clock, data synchronised only.

Test Plan:
- Frame 0x1C ('A'): start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1, 80 us bit period -> o_byte_valid with o_byte=1C; o_key_valid with code=1C, ext=0, brk=0; o_err stays 0.
- Sequence F0, 1C -> no event on F0; on 1C: code=1C, brk=1, ext=0. Then E0, F0, 75 -> one event: code=75, ext=1, brk=1. Flags then clear: next byte 75 gives ext=0, brk=0.
- Frame 0x1C with parity bit flipped to 1 -> o_err, err_code=1, no byte or key pulse. Subsequent F0 pending before it is discarded: next 1C gives brk=0.
- Stop bit driven 0 -> err_code=2. Clock stopped after 4 data bits for >100000 cycles -> err_code=3 at cycle TIMEOUT_CYC, o_busy falls. Next good frame decodes correctly.
- Glitch: 3-cycle low pulse on PS2_CLK in IDLE and mid-frame (FILTER_LEN=8) -> no `fe`, frame decodes unchanged. Byte AA -> o_sys_valid only.
- Assert i_rst mid-frame after 5 bits -> outputs 0 immediately. After release, a full 0x29 frame gives code=29 with no error.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive controller.
package ps2_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    DONE,
    ERR
  } state_t;

  // Reported error cause, held on o_err_code until the next error
  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_PARITY,
    ERR_FRAME,
    ERR_TIMEOUT
  } err_code_t;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  // Bytes the keyboard sends about itself rather than about a key
  localparam int N_SYS = 6;
  localparam logic [7:0] SYS_BYTES [N_SYS] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  function automatic logic is_sys_byte(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_SYS; i++) begin
      if (b == SYS_BYTES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_if.sv
// Event bus from the PS/2 receive controller to the game logic.
// All *_valid / o_err signals are single-cycle pulses with no ready
// back-pressure: a consumer must accept on the cycle the pulse is high.
// Data outputs (o_byte, o_key_*, o_err_code) hold between pulses.
interface ps2_kbd_ctrl_if;
  import ps2_pkg::*;

  logic       o_byte_valid;
  logic [7:0] o_byte;
  logic       o_key_valid;
  logic [7:0] o_key_code;
  logic       o_key_ext;
  logic       o_key_break;
  logic       o_sys_valid;
  logic       o_err;
  logic [1:0] o_err_code;
  logic       o_busy;
  state_t     o_state;

  modport master (
    output o_byte_valid, o_byte, o_key_valid, o_key_code, o_key_ext,
           o_key_break, o_sys_valid, o_err, o_err_code, o_busy, o_state
  );

  modport slave (
    input  o_byte_valid, o_byte, o_key_valid, o_key_code, o_key_ext,
           o_key_break, o_sys_valid, o_err, o_err_code, o_busy, o_state
  );

endinterface

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser plus glitch filter for the PS/2 clock line.
// Emits a one-cycle strobe on each filtered 1->0 transition.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_fe
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    r_sync;
  logic          r_filt;
  logic [CW-1:0] r_cnt;
  logic          r_fe;

  // Bring the asynchronous pin into the i_clk domain; idle line is high
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], i_raw};
  end

  // Change filtered level only after FILTER_LEN consecutive differing samples
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_filt <= 1'b1;
      r_cnt  <= '0;
      r_fe   <= 1'b0;
    end else begin
      r_fe <= 1'b0;
      if (r_sync[1] == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_filt <= r_sync[1];
        r_cnt  <= '0;
        r_fe   <= r_filt;  // old level 1 means this is a falling edge
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_fe = r_fe;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// Host-side PS/2 keyboard receiver: frames 11-bit device-to-host words,
// checks parity/stop/timeout and folds E0/F0 prefixes into key events.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_ps2_clk,
  input  logic           i_ps2_data,
  ps2_kbd_ctrl_if.master kbd
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYC);

  state_t        r_state, w_next;
  err_code_t     r_err_code, w_err_val;
  logic [1:0]    r_dat_sync;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_byte;
  logic          r_ext, r_brk;
  logic          r_key_valid, r_sys_valid;
  logic [7:0]    r_key_code;
  logic          r_key_ext, r_key_break;
  logic          w_fe, w_data, w_par_ok, w_in_frame, w_timeout;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_raw (i_ps2_clk),
    .o_fe  (w_fe)
  );

  // Data line is only synchronised; it is sampled mid-bit so needs no filter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_dat_sync <= 2'b11;
    else       r_dat_sync <= {r_dat_sync[0], i_ps2_data};
  end

  assign w_data     = r_dat_sync[1];
  assign w_par_ok   = ^{r_shift, r_par};
  assign w_in_frame = (r_state == DATA) || (r_state == PARITY) || (r_state == STOP);
  // A falling edge arriving on the limit cycle rescues the frame
  assign w_timeout  = w_in_frame && (r_to_cnt == TO_LIMIT) && !w_fe;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and error-cause selection
  always_comb begin
    w_next    = r_state;
    w_err_val = ERR_NONE;
    case (r_state)
      IDLE: begin
        if (w_fe && !w_data) w_next = DATA;
      end
      DATA: begin
        if (w_timeout) begin
          w_next    = ERR;
          w_err_val = ERR_TIMEOUT;
        end else if (w_fe && (r_bit_cnt == 3'd7)) begin
          w_next = PARITY;
        end
      end
      PARITY: begin
        if (w_timeout) begin
          w_next    = ERR;
          w_err_val = ERR_TIMEOUT;
        end else if (w_fe) begin
          w_next = STOP;
        end
      end
      STOP: begin
        if (w_timeout) begin
          w_next    = ERR;
          w_err_val = ERR_TIMEOUT;
        end else if (w_fe) begin
          if (!w_par_ok) begin
            w_next    = ERR;
            w_err_val = ERR_PARITY;
          end else if (!w_data) begin
            w_next    = ERR;
            w_err_val = ERR_FRAME;
          end else begin
            w_next = DONE;
          end
        end
      end
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Shift register, bit counter and parity capture on each falling edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
    end else if (w_fe) begin
      case (r_state)
        IDLE:   r_bit_cnt <= '0;
        DATA: begin
          r_shift   <= {w_data, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        PARITY: r_par <= w_data;
        default: ;
      endcase
    end
  end

  // Inter-edge watchdog: cleared by every edge and while idle, saturates at the limit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_to_cnt <= '0;
    end else if (w_fe || (r_state == IDLE)) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_LIMIT) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Latch the good byte and the error cause as the FSM commits to DONE/ERR
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_byte     <= '0;
      r_err_code <= ERR_NONE;
    end else begin
      if ((r_state == STOP) && (w_next == DONE)) r_byte <= r_shift;
      if ((r_state != ERR) && (w_next == ERR))   r_err_code <= w_err_val;
    end
  end

  // Prefix folding: runs in the DONE cycle so events appear one cycle later
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_key_valid <= 1'b0;
      r_sys_valid <= 1'b0;
      r_key_code  <= '0;
      r_key_ext   <= 1'b0;
      r_key_break <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_sys_valid <= 1'b0;
      if (r_state == ERR) begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end else if (r_state == DONE) begin
        if (r_byte == PREFIX_EXT) begin
          r_ext <= 1'b1;
        end else if (r_byte == PREFIX_BRK) begin
          r_brk <= 1'b1;
        end else if (is_sys_byte(r_byte) && !r_ext && !r_brk) begin
          r_sys_valid <= 1'b1;
        end else begin
          r_key_valid <= 1'b1;
          r_key_code  <= r_byte;
          r_key_ext   <= r_ext;
          r_key_break <= r_brk;
          r_ext       <= 1'b0;
          r_brk       <= 1'b0;
        end
      end
    end
  end

  assign kbd.o_byte_valid = (r_state == DONE);
  assign kbd.o_byte       = r_byte;
  assign kbd.o_key_valid  = r_key_valid;
  assign kbd.o_key_code   = r_key_code;
  assign kbd.o_key_ext    = r_key_ext;
  assign kbd.o_key_break  = r_key_break;
  assign kbd.o_sys_valid  = r_sys_valid;
  assign kbd.o_err        = (r_state == ERR);
  assign kbd.o_err_code   = r_err_code;
  assign kbd.o_busy       = (r_state != IDLE);
  assign kbd.o_state      = r_state;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: drives PS/2 frames on the raw pins and
// checks byte, key, system and error events against hand-computed values.
module tb_ps2_kbd_ctrl;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 1000;
  localparam int HALF        = 40;   // PS/2 clock half-period in i_clk cycles

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  int   cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_kbd_ctrl_if kbd ();

  ps2_kbd_ctrl #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ps2_clk  (ps2_clk),
    .i_ps2_data (ps2_data),
    .kbd        (kbd)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];    // {ext, brk, code}
  int n_byte_ev = 0, n_err_ev = 0, n_sys_ev = 0, n_key_ev = 0, n_unexp = 0;
  int err_cyc = 0;
  int t_fall = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (kbd.o_byte_valid) n_byte_ev++;
      if (kbd.o_sys_valid)  n_sys_ev++;
      if (kbd.o_err) begin
        n_err_ev++;
        err_cyc = cyc;
      end
      if (kbd.o_key_valid) begin
        n_key_ev++;
        if (exp_q.size() == 0) begin
          n_unexp++;
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          chk("key_code", {24'd0, kbd.o_key_code}, {24'd0, e[7:0]});
          chk("key_ext", {31'd0, kbd.o_key_ext}, {31'd0, e[9]});
          chk("key_brk", {31'd0, kbd.o_key_break}, {31'd0, e[8]});
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    ps2_data = b;
    wait_cyc(HALF / 2);
    ps2_clk = 1'b0;
    t_fall  = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    if (glitch) begin
      wait_cyc(15);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(HALF / 2);
    end else begin
      wait_cyc(HALF / 2);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip,
                            input logic stop_b, input int glitch_bit);
    logic p;
    p = ~(^d) ^ par_flip;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], i == glitch_bit);
    send_bit(p, 1'b0);
    send_bit(stop_b, 1'b0);
    ps2_data = 1'b1;
    wait_cyc(10);
  endtask

  task automatic good(input logic [7:0] d);
    send_frame(d, 1'b0, 1'b1, -1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(20 * 80000);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int b0, e0, k0, s0;
    bit seen;

    // reset state
    wait_cyc(5);
    chk("rst_busy", {31'd0, kbd.o_busy}, 32'd0);
    chk("rst_byte", {24'd0, kbd.o_byte}, 32'd0);
    chk("rst_err",  {31'd0, kbd.o_err}, 32'd0);
    rst = 1'b0;
    wait_cyc(20);
    chk("rst_code", {30'd0, kbd.o_err_code}, 32'd0);
    chk("rst_key",  {24'd0, kbd.o_key_code}, 32'd0);

    // plain make code 1C
    b0 = n_byte_ev; e0 = n_err_ev;
    exp_q.push_back({2'b00, 8'h1C});
    good(8'h1C);
    chk("a_byte",   {24'd0, kbd.o_byte}, 32'h1C);
    chk("a_nbyte",  n_byte_ev - b0, 32'd1);
    chk("a_noerr",  n_err_ev - e0, 32'd0);
    chk("a_idle",   {31'd0, kbd.o_busy}, 32'd0);

    // break, extended break, then flags cleared
    exp_q.push_back({2'b01, 8'h1C});
    good(8'hF0); good(8'h1C);
    exp_q.push_back({2'b11, 8'h75});
    good(8'hE0); good(8'hF0); good(8'h75);
    exp_q.push_back({2'b00, 8'h75});
    good(8'h75);
    // E0 E0 keeps ext; F0 then E0 keeps brk
    exp_q.push_back({2'b10, 8'h6B});
    good(8'hE0); good(8'hE0); good(8'h6B);
    exp_q.push_back({2'b11, 8'h74});
    good(8'hF0); good(8'hE0); good(8'h74);
    chk("seq_byte", {24'd0, kbd.o_byte}, 32'h74);

    // parity error drops byte and pending F0
    good(8'hF0);
    b0 = n_byte_ev; e0 = n_err_ev; k0 = n_key_ev;
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    chk("par_nerr",  n_err_ev - e0, 32'd1);
    chk("par_code",  {30'd0, kbd.o_err_code}, 32'd1);
    chk("par_nbyte", n_byte_ev - b0, 32'd0);
    chk("par_nkey",  n_key_ev - k0, 32'd0);
    exp_q.push_back({2'b00, 8'h1C});
    good(8'h1C);

    // stop bit low
    e0 = n_err_ev; b0 = n_byte_ev;
    send_frame(8'h1C, 1'b0, 1'b0, -1);
    chk("stop_nerr",  n_err_ev - e0, 32'd1);
    chk("stop_code",  {30'd0, kbd.o_err_code}, 32'd2);
    chk("stop_nbyte", n_byte_ev - b0, 32'd0);
    ps2_data = 1'b1;
    wait_cyc(20);

    // timeout after 4 data bits
    e0 = n_err_ev;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
    wait_cyc(TIMEOUT_CYC / 2);
    chk("to_busy_mid", {31'd0, kbd.o_busy}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT_CYC + 200 && !seen; i++) begin
      wait_cyc(1);
      if (n_err_ev != e0) seen = 1'b1;
    end
    chk("to_seen", {31'd0, seen}, 32'd1);
    chk("to_lat_lo", {31'd0, (err_cyc - t_fall) >= TIMEOUT_CYC}, 32'd1);
    chk("to_lat_hi", {31'd0, (err_cyc - t_fall) <= TIMEOUT_CYC + 30}, 32'd1);
    wait_cyc(2);
    chk("to_code", {30'd0, kbd.o_err_code}, 32'd3);
    chk("to_idle", {31'd0, kbd.o_busy}, 32'd0);
    ps2_data = 1'b1;
    wait_cyc(20);
    exp_q.push_back({2'b00, 8'h1C});
    good(8'h1C);
    chk("to_next", {24'd0, kbd.o_byte}, 32'h1C);

    // glitches: idle with data low, then mid-frame
    ps2_data = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(30);
    chk("gl_idle", {31'd0, kbd.o_busy}, 32'd0);
    ps2_data = 1'b1;
    wait_cyc(10);
    e0 = n_err_ev;
    exp_q.push_back({2'b00, 8'h5A});
    send_frame(8'h5A, 1'b0, 1'b1, 3);
    chk("gl_byte", {24'd0, kbd.o_byte}, 32'h5A);
    chk("gl_noerr", n_err_ev - e0, 32'd0);

    // system byte
    s0 = n_sys_ev; k0 = n_key_ev;
    good(8'hAA);
    chk("sys_n",    n_sys_ev - s0, 32'd1);
    chk("sys_nkey", n_key_ev - k0, 32'd0);
    chk("sys_byte", {24'd0, kbd.o_byte}, 32'hAA);

    // reset mid-frame
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mr_busy", {31'd0, kbd.o_busy}, 32'd0);
    chk("mr_byte", {24'd0, kbd.o_byte}, 32'd0);
    chk("mr_key",  {24'd0, kbd.o_key_code}, 32'd0);
    chk("mr_code", {30'd0, kbd.o_err_code}, 32'd0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(30);
    e0 = n_err_ev;
    exp_q.push_back({2'b00, 8'h29});
    good(8'h29);
    chk("mr_next", {24'd0, kbd.o_byte}, 32'h29);
    chk("mr_noerr", n_err_ev - e0, 32'd0);

    // final report
    wait_cyc(10);
    chk("q_left", exp_q.size(), 32'd0);
    chk("unexp",  n_unexp, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
